// File: rtl/ex_muldiv.sv
// Iterative 32-cycle multiply/divide unit owning the HI/LO registers (MULT/DIV/MTHI/MTLO).
// Define MULDIV_SIGNED_EN to build the signed abs/fix-up path for MULT/DIV; otherwise they run unsigned.
module ex_muldiv #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] DIV0_LO = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic [2:0]       opE,
  input  logic [WIDTH-1:0] srcAE,
  input  logic [WIDTH-1:0] srcBE,
  input  logic             flushE,
  input  logic             hiloReadE,
  output logic             busyE,
  output logic             stallE,
  output logic             doneE,
  output logic [WIDTH-1:0] hiE,
  output logic [WIDTH-1:0] loE
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_MULT  = 3'd3;
  localparam logic [2:0] OP_DIV   = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t               state;
  logic [CNT_W-1:0]     count;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opnd;
  logic [WIDTH-1:0]     aRaw;
  logic                 isDiv;
  logic                 divZero;

  logic                 isMulDivOp;
  logic                 isDivOp;
  logic [WIDTH-1:0]     absA;
  logic [WIDTH-1:0]     absB;
  logic [WIDTH:0]       mulSum;
  logic [2*WIDTH-1:0]   mulNext;
  logic [WIDTH:0]       divShift;
  logic                 divGe;
  logic [WIDTH-1:0]     divDiff;
  logic [2*WIDTH-1:0]   divNext;
  logic [WIDTH-1:0]     resHi;
  logic [WIDTH-1:0]     resLo;

  assign isMulDivOp = (opE == OP_MULTU) || (opE == OP_DIVU) ||
                      (opE == OP_MULT)  || (opE == OP_DIV);
  assign isDivOp    = (opE == OP_DIVU) || (opE == OP_DIV);

`ifdef MULDIV_SIGNED_EN
  logic isSignedOp;
  logic negA;
  logic negB;
  logic negRes;
  logic negRem;

  function automatic logic [WIDTH-1:0] absVal(input logic signed [WIDTH-1:0] v,
                                              input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] negWide(input logic signed [2*WIDTH-1:0] v);
    return -v;
  endfunction

  assign isSignedOp = (opE == OP_MULT) || (opE == OP_DIV);
  assign negA       = isSignedOp & srcAE[WIDTH-1];
  assign negB       = isSignedOp & srcBE[WIDTH-1];
  assign absA       = absVal(srcAE, negA);
  assign absB       = absVal(srcBE, negB);
`else
  assign absA = srcAE;
  assign absB = srcBE;
`endif

  // Shift-add multiply: acc = {partial product, remaining multiplier bits}
  assign mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mulNext = {mulSum, acc[WIDTH-1:1]};

  // Restoring divide: acc = {partial remainder, dividend shifting into quotient}
  assign divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign divGe    = divShift >= {1'b0, opnd};
  assign divDiff  = divShift[WIDTH-1:0] - opnd;
  assign divNext  = divGe ? {divDiff, acc[WIDTH-2:0], 1'b1}
                          : {divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

  always_comb begin
    resHi = acc[2*WIDTH-1:WIDTH];
    resLo = acc[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
    if (!isDiv && negRes) begin
      {resHi, resLo} = negWide(acc);
    end
    if (isDiv && negRes) resLo = absVal(acc[WIDTH-1:0], 1'b1);
    if (isDiv && negRem) resHi = absVal(acc[2*WIDTH-1:WIDTH], 1'b1);
`endif
    if (divZero) begin
      resHi = aRaw;
      resLo = DIV0_LO;
    end
  end

  assign busyE  = (state != IDLE);
  assign stallE = busyE & (startE | hiloReadE);
  // A flush landing on the DONE cycle cancels the commit, so the pulse is masked with it.
  assign doneE  = (state == DONE) & ~flushE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      acc     <= '0;
      opnd    <= '0;
      aRaw    <= '0;
      isDiv   <= 1'b0;
      divZero <= 1'b0;
      hiE     <= '0;
      loE     <= '0;
`ifdef MULDIV_SIGNED_EN
      negRes  <= 1'b0;
      negRem  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (startE && !flushE) begin
            if (isMulDivOp) begin
              state   <= RUN;
              count   <= '0;
              isDiv   <= isDivOp;
              divZero <= isDivOp && (srcBE == '0);
              aRaw    <= srcAE;
              opnd    <= isDivOp ? absB : absA;
              acc     <= {{WIDTH{1'b0}}, (isDivOp ? absA : absB)};
`ifdef MULDIV_SIGNED_EN
              negRes  <= negA ^ negB;
              negRem  <= negA;
`endif
            end else if (opE == OP_MTHI) begin
              hiE <= srcAE;
            end else if (opE == OP_MTLO) begin
              loE <= srcAE;
            end
          end
        end
        RUN: begin
          if (flushE) begin
            state <= IDLE;
          end else begin
            acc   <= isDiv ? divNext : mulNext;
            count <= count + 1'b1;
            if (count == CNT_W'(WIDTH - 1)) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          if (!flushE) begin
            hiE <= resHi;
            loE <= resLo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: scoreboard of expected {HI,LO} checked when each op retires.
module tb_ex_muldiv;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_MULT  = 3'd3;
  localparam logic [2:0] OP_DIV   = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_NONE7 = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        startE;
  logic [2:0]  opE;
  logic [31:0] srcAE;
  logic [31:0] srcBE;
  logic        flushE;
  logic        hiloReadE;
  logic        busyE;
  logic        stallE;
  logic        doneE;
  logic [31:0] hiE;
  logic [31:0] loE;

  int checks = 0;
  int errors = 0;
  logic [63:0] expQ[$];

  ex_muldiv dut (
    .clk(clk), .rst(rst), .startE(startE), .opE(opE), .srcAE(srcAE), .srcBE(srcBE),
    .flushE(flushE), .hiloReadE(hiloReadE), .busyE(busyE), .stallE(stallE),
    .doneE(doneE), .hiE(hiE), .loE(loE)
  );

  always #5 clk = ~clk;

  // Reference: native SV arithmetic, signed only when the unit is built signed.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic               sgn;
    logic               div;
    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        q;
    logic [31:0]        r;
    sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
    sgn = (op == OP_MULT) || (op == OP_DIV);
`endif
    div = (op == OP_DIVU) || (op == OP_DIV);
    if (!div) begin
      if (sgn) begin
        sa64 = $signed(a);
        sb64 = $signed(b);
        return sa64 * sb64;
      end
      return {32'd0, a} * {32'd0, b};
    end
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (sgn) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
      sa = a;
      sb = b;
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs;
    startE = 1'b0; opE = OP_NONE; srcAE = '0; srcBE = '0; flushE = 1'b0; hiloReadE = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    startE = 1'b1; opE = op; srcAE = a; srcBE = b;
    if (push) expQ.push_back(model(op, a, b));
    tick;
    startE = 1'b0; opE = OP_NONE;
  endtask

  task automatic moveTo(input logic [2:0] op, input logic [31:0] v);
    startE = 1'b1; opE = op; srcAE = v;
    tick;
    startE = 1'b0; opE = OP_NONE;
  endtask

  task automatic checkHiLo(input string name);
    logic [63:0] exp;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty, got %h_%h", name, hiE, loE);
    end else begin
      exp = expQ.pop_front();
      if ({hiE, loE} !== exp)
        begin errors++; $display("FAIL %s hilo got %h_%h expected %h", name, hiE, loE, exp); end
    end
  endtask

  task automatic waitDone(input string name);
    int busyCnt;
    int doneCnt;
    int cyc;
    busyCnt = 0; doneCnt = 0; cyc = 0;
    #1;
    while (busyE && cyc < 200) begin
      busyCnt++;
      if (doneE) doneCnt++;
      tick; #1; cyc++;
    end
    checks++;
    if (busyCnt !== 33)
      begin errors++; $display("FAIL %s busy cycles got %0d expected 33", name, busyCnt); end
    checks++;
    if (doneCnt !== 1)
      begin errors++; $display("FAIL %s done pulses got %0d expected 1", name, doneCnt); end
    checkHiLo(name);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick;
    checks++;
    if ({hiE, loE} !== 64'd0)
      begin errors++; $display("FAIL reset_hilo got %h_%h expected 0", hiE, loE); end
    checks++;
    if ({busyE, doneE, stallE} !== 3'b000)
      begin errors++; $display("FAIL reset_ctrl got %b expected 000", {busyE, doneE, stallE}); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_multu;
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1); waitDone("multu_max");
    issue(OP_MULTU, 32'h12345678, 32'h9ABCDEF0, 1); waitDone("multu_mix");
    issue(OP_MULTU, 32'h00000000, 32'hDEADBEEF, 1); waitDone("multu_zero");
    issue(OP_MULTU, 32'h00010001, 32'h0000FFFF, 1); waitDone("multu_small");
  endtask

  task automatic test_divu;
    issue(OP_DIVU, 32'd100, 32'd7, 1);          waitDone("divu_100_7");
    issue(OP_DIVU, 32'd5, 32'd0, 1);            waitDone("divu_by_zero");
    issue(OP_DIVU, 32'hFFFFFFFF, 32'd1, 1);     waitDone("divu_by_one");
    issue(OP_DIVU, 32'd7, 32'd100, 1);          waitDone("divu_small");
    issue(OP_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFE, 1); waitDone("divu_big");
  endtask

  task automatic test_signed;
    issue(OP_MULT, 32'hFFFFFFFD, 32'd5, 1);        waitDone("mult_neg3_5");
    issue(OP_MULT, 32'h80000000, 32'h80000000, 1); waitDone("mult_min_min");
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1);         waitDone("div_neg7_2");
    issue(OP_DIV, 32'd7, 32'hFFFFFFFE, 1);         waitDone("div_7_neg2");
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1);  waitDone("div_min_neg1");
    issue(OP_DIV, 32'hFFFFFFF9, 32'd0, 1);         waitDone("div_by_zero");
  endtask

  task automatic test_stall;
    int n;
    int cyc;
    issue(OP_DIVU, 32'd1000, 32'd3, 1);
    repeat (4) tick;
    hiloReadE = 1'b1;
    n = 0; cyc = 0;
    #1;
    while (busyE && cyc < 100) begin
      checks++;
      if (stallE !== 1'b1) begin errors++; $display("FAIL stall_hilo got %b expected 1", stallE); end
      n++; tick; #1; cyc++;
    end
    checks++;
    if (n !== 29) begin errors++; $display("FAIL stall_len got %0d expected 29", n); end
    checks++;
    if (stallE !== 1'b0) begin errors++; $display("FAIL stall_release got %b expected 0", stallE); end
    checkHiLo("stall_divu");
    hiloReadE = 1'b0;

    issue(OP_DIVU, 32'd77, 32'd5, 1);
    repeat (2) tick;
    startE = 1'b1; opE = OP_MULTU; srcAE = 32'h0001_0003; srcBE = 32'h0002_0005;
    expQ.push_back(model(OP_MULTU, 32'h0001_0003, 32'h0002_0005));
    cyc = 0;
    #1;
    while (busyE && cyc < 100) begin
      checks++;
      if (stallE !== 1'b1) begin errors++; $display("FAIL b2b_stall got %b expected 1", stallE); end
      tick; #1; cyc++;
    end
    checks++;
    if (stallE !== 1'b0) begin errors++; $display("FAIL b2b_release got %b expected 0", stallE); end
    checkHiLo("b2b_first");
    tick;
    startE = 1'b0; opE = OP_NONE;
    waitDone("b2b_second");
  endtask

  task automatic test_mthilo;
    int cyc;
    moveTo(OP_MTHI, 32'h00001234);
    checks++;
    if (hiE !== 32'h1234 || busyE !== 1'b0)
      begin errors++; $display("FAIL mthi got hi=%h busy=%b expected 1234/0", hiE, busyE); end
    moveTo(OP_MTLO, 32'h0000ABCD);
    checks++;
    if (loE !== 32'hABCD || hiE !== 32'h1234 || busyE !== 1'b0)
      begin errors++; $display("FAIL mtlo got %h_%h busy=%b expected 1234_abcd/0", hiE, loE, busyE); end
    flushE = 1'b1;
    moveTo(OP_MTHI, 32'hDEAD0000);
    flushE = 1'b0;
    checks++;
    if (hiE !== 32'h1234) begin errors++; $display("FAIL mthi_flushed got %h expected 1234", hiE); end
    moveTo(OP_NONE, 32'h11111111);
    moveTo(OP_NONE7, 32'h22222222);
    checks++;
    if ({hiE, loE} !== 64'h00001234_0000ABCD || busyE !== 1'b0)
      begin errors++; $display("FAIL op_none got %h_%h busy=%b expected 1234_abcd/0", hiE, loE, busyE); end

    issue(OP_MULTU, 32'd6, 32'd7, 1);
    startE = 1'b1; opE = OP_MTHI; srcAE = 32'h00000099;
    #1;
    checks++;
    if (stallE !== 1'b1) begin errors++; $display("FAIL mthi_busy_stall got %b expected 1", stallE); end
    cyc = 0;
    while (busyE && cyc < 100) begin tick; #1; cyc++; end
    checkHiLo("mthi_busy_result");
    tick;
    startE = 1'b0; opE = OP_NONE;
    checks++;
    if (hiE !== 32'h99 || loE !== 32'd42)
      begin errors++; $display("FAIL mthi_after_busy got %h_%h expected 00000099_0000002a", hiE, loE); end
  endtask

  task automatic test_flush;
    int dn;
    moveTo(OP_MTHI, 32'h0000AAAA);
    moveTo(OP_MTLO, 32'h00005555);
    issue(OP_MULTU, 32'h12345678, 32'h9ABCDEF0, 0);
    repeat (10) tick;
    flushE = 1'b1;
    tick;
    flushE = 1'b0;
    checks++;
    if (busyE !== 1'b0) begin errors++; $display("FAIL flush_idle busy got %b expected 0", busyE); end
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (doneE) dn++;
      tick;
    end
    checks++;
    if (dn !== 0) begin errors++; $display("FAIL flush_nodone pulses got %0d expected 0", dn); end
    checks++;
    if ({hiE, loE} !== 64'h0000AAAA_00005555)
      begin errors++; $display("FAIL flush_hilo got %h_%h expected 0000aaaa_00005555", hiE, loE); end

    issue(OP_MULTU, 32'd3, 32'd3, 0);
    repeat (32) tick;
    flushE = 1'b1;
    #1;
    checks++;
    if (busyE !== 1'b1 || doneE !== 1'b0)
      begin errors++; $display("FAIL flush_done got busy=%b done=%b expected 1/0", busyE, doneE); end
    tick;
    flushE = 1'b0;
    checks++;
    if (busyE !== 1'b0 || {hiE, loE} !== 64'h0000AAAA_00005555)
      begin errors++; $display("FAIL flush_done_hilo got %h_%h busy=%b", hiE, loE, busyE); end

    issue(OP_MULTU, 32'd3, 32'd3, 1);
    waitDone("after_flush");

    moveTo(OP_MTHI, 32'h0000AAAA);
    moveTo(OP_MTLO, 32'h00005555);
    issue(OP_MULTU, 32'h12345678, 32'h9ABCDEF0, 0);
    repeat (10) tick;
    rst = 1'b1;
    #1;
    checks++;
    if ({hiE, loE} !== 64'd0 || {busyE, doneE, stallE} !== 3'b000)
      begin errors++; $display("FAIL reset_mid got %h_%h ctrl=%b expected 0", hiE, loE, {busyE, doneE, stallE}); end
    tick;
    rst = 1'b0;
    tick;
    issue(OP_DIVU, 32'd100, 32'd7, 1);
    waitDone("after_reset");
  endtask

  initial begin
    idleInputs;
    test_reset;
    test_multu;
    test_divu;
    test_signed;
    test_stall;
    test_mthilo;
    test_flush;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the execute stage; consumes operands and control issued by the ID/EX pipeline register.
- Owns the architectural HI/LO registers and executes MULT/MULTU/DIV/DIVU (32-cycle radix-2) plus single-cycle MTHI/MTLO.
- Raises a stall to the hazard logic while busy, so that a HI/LO consumer or a new mul/div waits in EX.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- DIV0_LO, 32'hFFFFFFFF, LO value written on divide-by-zero.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- startE  in  1  EX instruction is a mul/div/MTHI/MTLO; qualifies opE.
- opE  in  3  000 none, 001 MULTU, 010 DIVU, 011 MULT, 100 DIV, 101 MTHI, 110 MTLO, 111 none.
- srcAE  in  WIDTH  rs operand (forwarded); dividend/multiplicand; MTHI/MTLO data.
- srcBE  in  WIDTH  rt operand (forwarded); divisor/multiplier.
- flushE  in  1  cancel: abort in-flight op, ignore startE this cycle.
- hiloReadE  in  1  EX instruction reads HI/LO (MFHI/MFLO).
- busyE  out  1  unit in RUN or DONE.
- stallE  out  1  hold IF/ID/EX, bubble into MEM.
- doneE  out  1  one-cycle pulse when a mul/div result commits.
- hiE  out  WIDTH  HI register.
- loE  out  WIDTH  LO register.

Behaviour:
- Reset (async, any state): state=IDLE, hiE=0, loE=0, busyE=0, doneE=0, counter=0, internal accumulators=0.
- States:
  - IDLE: on edge with startE & !flushE & op in {MULTU,DIVU,MULT,DIV}, latch operands and go to RUN with count=0.
  - RUN: one iteration per cycle; count 0..31; at count==31 go to DONE.
  - DONE: sign fix-up; HI/LO written at the end of this cycle; doneE=1; return to IDLE.
  - Timing: busyE=1 in RUN and DONE; 33 busy cycles total; new HI/LO visible the cycle after DONE.
- MTHI/MTLO in IDLE (startE & !flushE): write hiE or loE with srcAE at that edge; no state change; busyE stays 0.
- Op none/111 with startE: no effect.
- stallE = busyE & (startE | hiloReadE). Combinational; a stalled instruction re-presents startE each cycle until the unit is IDLE, then issues normally.
- startE while busyE: never accepted; stallE holds it.
- Multiply: shift-add on |A|, |B|. Product is 64 bits {HI,LO}, mod 2^64.
- Divide: restoring, on |A| / |B|. LO=quotient, HI=remainder.
- Divide-by-zero (B==0), any divide op: skip the sign fix-up; HI=srcA as latched, LO=DIV0_LO. Still takes the full 33 cycles.
- Signed fix-up:
  - Product negated if sign(A)^sign(B).
  - Quotient negated if sign(A)^sign(B).
  - Remainder takes sign(A).
  - 0x80000000 / -1 yields LO=0x80000000, HI=0.
- flushE in RUN or DONE: go to IDLE next edge; HI/LO unchanged; no doneE pulse.
- flushE with startE in IDLE: ignore the start, including MTHI/MTLO.
- Reset mid-operation: immediate async return to the reset values; no partial commit.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined: MULT/DIV (011/100) perform the signed abs/fix-up path as above.
- Undefined: no abs/negate logic is synthesised; MULT behaves exactly as MULTU and DIV exactly as DIVU. Latency is unchanged.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF → after 33 busy cycles, doneE pulse, HI=0xFFFFFFFE, LO=0x00000001.
- DIVU 100/7 → LO=14, HI=2. DIVU 5/0 → HI=5, LO=0xFFFFFFFF, still 33 cycles.
- MULT −3×5 with MULDIV_SIGNED_EN → HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Without the macro, MULT gives HI=0x00000004, LO=0xFFFFFFF1.
- DIVU issued, then hiloReadE=1 at cycle 5 → stallE=1 through DONE, 0 in the cycle after. A second MULTU presented while busy is accepted only after IDLE, with correct result.
- MTHI 0x1234 then MTLO 0xABCD while idle → HI/LO updated the next cycle, busyE never asserted. MTHI while busy → stallE=1.
- MULTU started (HI/LO preloaded 0xAAAA/0x5555), flushE at count 10 → IDLE, no doneE, HI/LO stay 0xAAAA/0x5555. Repeat with rst at count 10 → all outputs 0 immediately.
